// File: rtl/motor_array_controller.sv
// ---------------------------------------------------------------------------
// motor_array_controller
//
// Drive controller for an N-motor differential platform.
//
// Command path:
//   movement_sel -> 2-flop synchroniser -> stability filter -> cmd_active
//   -> per-side decode -> optional right-side mirroring -> enable gating
//   -> one protection FSM per motor -> sel_protected
//
// Each protection FSM (IDLE / RUN / DEAD) inserts DEAD_CYCLES clocks with
// both bridge inputs low on every exit from a driven state. A bridge pair
// is never driven 2'b11.
//
// Ports:
//   clk            in   system clock, rising-edge logic
//   rst            in   asynchronous, active-low reset
//   movement_sel   in   [3:0] raw movement command, asynchronous to clk
//   enable         in   synchronous drive enable; low requests stop on all motors
//   sel_protected  out  [2*N_MOTORS-1:0] bridge inputs; bit 2i = IN1 (forward),
//                       bit 2i+1 = IN2 (reverse) of motor i
//   cmd_active     out  [3:0] currently committed command
//   busy           out  high while any motor is in its dead time
//   fsm_state_dbg  out  [2*N_MOTORS-1:0] per-motor FSM state (2 bits each),
//                       00 = IDLE, 01 = RUN, 10 = DEAD
//
// Parameters:
//   N_MOTORS      even, >= 2. Motors 0..N/2-1 are the left side.
//   DEAD_CYCLES   >= 1, low cycles inserted on each exit from RUN.
//   STABLE_CYCLES >= 1, cycles the synchronised command must hold.
//   INVERT_RIGHT  swaps forward/reverse on right-side motors.
// ---------------------------------------------------------------------------
module motor_array_controller #(
    parameter int N_MOTORS      = 4,
    parameter int DEAD_CYCLES   = 50000,
    parameter int STABLE_CYCLES = 1000,
    parameter bit INVERT_RIGHT  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            movement_sel,
    input  logic                  enable,
    output logic [2*N_MOTORS-1:0] sel_protected,
    output logic [3:0]            cmd_active,
    output logic                  busy,
    output logic [2*N_MOTORS-1:0] fsm_state_dbg
);

    localparam int HALF = N_MOTORS / 2;

    // Counter widths sized so that the parameter value itself fits; this
    // keeps the widths nonzero even when a parameter is 1.
    localparam int DW = $clog2(DEAD_CYCLES + 1);
    localparam int SW = $clog2(STABLE_CYCLES + 1);

    localparam logic [DW-1:0] DEAD_LOAD   = DW'(DEAD_CYCLES - 1);
    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DEAD = 2'b10
    } state_e;

    // -----------------------------------------------------------------------
    // Synchroniser and stability filter
    // -----------------------------------------------------------------------
    logic [3:0]    sync1_q;
    logic [3:0]    sync2_q;
    logic [3:0]    cmd_q;
    logic [SW-1:0] stab_cnt_q;
    logic          stab_done;

    // stab_cnt_q == k means sync2_q has held its current value for k+1
    // cycles. Once it has held STABLE_CYCLES cycles it is committed on the
    // next edge. sync1_q != sync2_q means sync2_q changes on this edge, so
    // the count restarts for the new value.
    assign stab_done = (stab_cnt_q == STABLE_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            cmd_q      <= '0;
            stab_cnt_q <= '0;
        end else begin
            sync1_q <= movement_sel;
            sync2_q <= sync1_q;
            if (stab_done) begin
                cmd_q <= sync2_q;
            end
            if (sync1_q != sync2_q) begin
                stab_cnt_q <= '0;
            end else if (!stab_done) begin
                stab_cnt_q <= stab_cnt_q + 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Decode: side codes 01 = forward, 10 = reverse, 00 = stop.
    // -----------------------------------------------------------------------
    logic [1:0] left_req;
    logic [1:0] right_raw;
    logic [1:0] right_req;

    always_comb begin
        left_req  = 2'b00;
        right_raw = 2'b00;
        case (cmd_q)
            4'd1: begin left_req = 2'b01; right_raw = 2'b01; end // forward
            4'd2: begin left_req = 2'b10; right_raw = 2'b10; end // backward
            4'd3: begin left_req = 2'b00; right_raw = 2'b01; end // pivot left
            4'd4: begin left_req = 2'b01; right_raw = 2'b00; end // pivot right
            4'd5: begin left_req = 2'b10; right_raw = 2'b01; end // spin left
            4'd6: begin left_req = 2'b01; right_raw = 2'b10; end // spin right
            default: begin end                                    // stop / illegal
        endcase
        // Mirror-mounted right motors: swap IN1/IN2. A swap never produces
        // 2'b11 from a legal side code.
        right_req = INVERT_RIGHT ? {right_raw[0], right_raw[1]} : right_raw;
    end

    // Per-motor requests after enable gating.
    logic [2*N_MOTORS-1:0] req_vec;

    always_comb begin
        req_vec = '0;
        for (int m = 0; m < N_MOTORS; m++) begin
            if (enable) begin
                req_vec[2*m +: 2] = (m < HALF) ? left_req : right_req;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Protection FSMs, one per motor
    // -----------------------------------------------------------------------
    logic [N_MOTORS-1:0] dead_next;
    logic                busy_q;

    for (genvar m = 0; m < N_MOTORS; m++) begin : g_motor
        state_e        state_q;
        logic [1:0]    dir_q;
        logic [1:0]    out_q;
        logic [DW-1:0] cnt_q;
        logic [1:0]    req;

        assign req = req_vec[2*m +: 2];

        // True when this motor will be in DEAD after the coming edge; lets
        // busy be registered in step with the FSM state rather than a cycle
        // behind it.
        assign dead_next[m] = ((state_q == ST_RUN)  && (req != dir_q)) ||
                              ((state_q == ST_DEAD) && (cnt_q != '0));

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_q <= ST_IDLE;
                dir_q   <= 2'b00;
                out_q   <= 2'b00;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        out_q <= 2'b00;
                        if (req != 2'b00) begin
                            state_q <= ST_RUN;
                            dir_q   <= req;
                            out_q   <= req;
                        end
                    end
                    ST_RUN: begin
                        if (req != dir_q) begin
                            state_q <= ST_DEAD;
                            cnt_q   <= DEAD_LOAD;
                            out_q   <= 2'b00;
                        end
                    end
                    ST_DEAD: begin
                        // The dead time always runs to completion; the
                        // request is only looked at once the count is 0.
                        out_q <= 2'b00;
                        if (cnt_q == '0) begin
                            if (req == 2'b00) begin
                                state_q <= ST_IDLE;
                            end else begin
                                state_q <= ST_RUN;
                                dir_q   <= req;
                                out_q   <= req;
                            end
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        out_q   <= 2'b00;
                    end
                endcase
            end
        end

        assign sel_protected[2*m +: 2] = out_q;
        assign fsm_state_dbg[2*m +: 2] = state_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= |dead_next;
        end
    end

    assign busy       = busy_q;
    assign cmd_active = cmd_q;

endmodule

// File: tb/tb_motor_array_controller.sv
// ---------------------------------------------------------------------------
// tb_motor_array_controller
//
// Two instances share all inputs: dut_a with INVERT_RIGHT=0 and dut_b with
// INVERT_RIGHT=1. A behavioural model (synchroniser pipeline, hold-length
// counter, per-motor output plus remaining-dead-time countdown) is stepped on
// every rising edge; a compare process checks both instances against it on
// every falling edge. Directed scenarios add literal expectations, then a
// randomized phase drives commands, enable and occasional resets.
// Valid/ready handshakes: none; all inputs are level-sampled on clk.
// ---------------------------------------------------------------------------
module tb_motor_array_controller;

    localparam int N      = 4;
    localparam int DEAD   = 4;
    localparam int STABLE = 2;

    // ----------------------------------------------------------------- clock/reset
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] movement_sel = 4'd0;

    always #5 clk = ~clk;

    logic [2*N-1:0] sel_a, sel_b, st_a, st_b;
    logic [3:0]     cmd_a, cmd_b;
    logic           busy_a, busy_b;

    motor_array_controller #(
        .N_MOTORS(N), .DEAD_CYCLES(DEAD), .STABLE_CYCLES(STABLE), .INVERT_RIGHT(1'b0)
    ) dut_a (
        .clk(clk), .rst(rst), .movement_sel(movement_sel), .enable(enable),
        .sel_protected(sel_a), .cmd_active(cmd_a), .busy(busy_a), .fsm_state_dbg(st_a)
    );

    motor_array_controller #(
        .N_MOTORS(N), .DEAD_CYCLES(DEAD), .STABLE_CYCLES(STABLE), .INVERT_RIGHT(1'b1)
    ) dut_b (
        .clk(clk), .rst(rst), .movement_sel(movement_sel), .enable(enable),
        .sel_protected(sel_b), .cmd_active(cmd_b), .busy(busy_b), .fsm_state_dbg(st_b)
    );

    // ----------------------------------------------------------------- scoreboard
    int compared   = 0;
    int mismatched = 0;
    bit chk_en     = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ----------------------------------------------------------------- model
    logic [3:0] m_s1, m_s2, m_cmd;
    int         m_held;               // cycles the synchronised value has held
    logic [1:0] m_out  [2][N];        // [instance][motor] bridge output
    int         m_dead [2][N];        // remaining low cycles of dead time
    logic [1:0] m_r;

    // {left, right} side codes for each command.
    function automatic logic [3:0] side_codes(input logic [3:0] c);
        case (c)
            4'd1:    return 4'b01_01;
            4'd2:    return 4'b10_10;
            4'd3:    return 4'b00_01;
            4'd4:    return 4'b01_00;
            4'd5:    return 4'b10_01;
            4'd6:    return 4'b01_10;
            default: return 4'b00_00;
        endcase
    endfunction

    function automatic logic [1:0] req_of(input int inst, input int m,
                                          input logic [3:0] c, input logic en);
        logic [3:0] codes;
        logic [1:0] r;
        if (!en) return 2'b00;
        codes = side_codes(c);
        if (m < N / 2) return codes[3:2];
        r = codes[1:0];
        if (inst == 1) return {r[0], r[1]};
        return r;
    endfunction

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_cmd = '0; m_held = 1;
        for (int i = 0; i < 2; i++)
            for (int m = 0; m < N; m++) begin
                m_out[i][m]  = 2'b00;
                m_dead[i][m] = 0;
            end
    endtask

    task automatic model_step();
        // Motors react to the command committed before this edge.
        for (int i = 0; i < 2; i++)
            for (int m = 0; m < N; m++) begin
                m_r = req_of(i, m, m_cmd, enable);
                if (m_dead[i][m] > 0) begin
                    m_dead[i][m]--;
                    if (m_dead[i][m] == 0) m_out[i][m] = m_r;
                end else if (m_out[i][m] != 2'b00 && m_r != m_out[i][m]) begin
                    m_out[i][m]  = 2'b00;
                    m_dead[i][m] = DEAD;
                end else if (m_out[i][m] == 2'b00) begin
                    m_out[i][m] = m_r;
                end
            end
        if (m_held >= STABLE) m_cmd = m_s2;
        if (m_s1 != m_s2) m_held = 1;
        else if (m_held < STABLE) m_held++;
        m_s2 = m_s1;
        m_s1 = movement_sel;
    endtask

    function automatic logic [2*N-1:0] exp_sel(input int inst);
        logic [2*N-1:0] v;
        for (int m = 0; m < N; m++) v[2*m +: 2] = m_out[inst][m];
        return v;
    endfunction

    function automatic logic exp_busy(input int inst);
        logic b = 1'b0;
        for (int m = 0; m < N; m++) if (m_dead[inst][m] > 0) b = 1'b1;
        return b;
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else model_step();
        end
    end

    // Per-cycle compare plus the no-11 invariant.
    initial forever begin
        @(negedge clk);
        for (int m = 0; m < N; m++) begin
            assert (sel_a[2*m +: 2] != 2'b11 && sel_b[2*m +: 2] != 2'b11)
            else begin
                mismatched++;
                $display("FAIL pair_11 motor %0d at %0t: a=%b b=%b required not 11",
                         m, $time, sel_a[2*m +: 2], sel_b[2*m +: 2]);
            end
        end
        if (chk_en) begin
            check("model_sel_a",  {24'd0, sel_a}, {24'd0, exp_sel(0)});
            check("model_sel_b",  {24'd0, sel_b}, {24'd0, exp_sel(1)});
            check("model_cmd_a",  {28'd0, cmd_a}, {28'd0, m_cmd});
            check("model_cmd_b",  {28'd0, cmd_b}, {28'd0, m_cmd});
            check("model_busy_a", {31'd0, busy_a}, {31'd0, exp_busy(0)});
            check("model_busy_b", {31'd0, busy_b}, {31'd0, exp_busy(1)});
        end
    end

    // ----------------------------------------------------------------- driver
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_a(input string name, input logic [7:0] sel_exp, input logic busy_exp);
        check({name, "_sel"},  {24'd0, sel_a}, {24'd0, sel_exp});
        check({name, "_busy"}, {31'd0, busy_a}, {31'd0, busy_exp});
    endtask

    initial begin
        tick(3);
        check("reset_sel",  {24'd0, sel_a}, 32'h00);
        check("reset_cmd",  {28'd0, cmd_a}, 32'h0);
        check("reset_busy", {31'd0, busy_a}, 32'h0);
        chk_en = 1'b1;
        #2 rst = 1'b1; enable = 1'b1;

        // Forward from reset: command applied just after edge 0.
        tick(1);
        movement_sel = 4'd1;
        tick(3);
        check("fwd_cmd_e3", {28'd0, cmd_a}, 32'h0);
        tick(1);
        check("fwd_cmd_e4", {28'd0, cmd_a}, 32'h1);
        check_a("fwd_e4", 8'h00, 1'b0);
        tick(1);
        check_a("fwd_e5", 8'h55, 1'b0);
        check("fwd_inv_sel", {24'd0, sel_b}, 32'hA5);

        // Forward -> backward.
        movement_sel = 4'd2;
        tick(4);
        check("bwd_cmd", {28'd0, cmd_a}, 32'h2);
        check_a("bwd_pre", 8'h55, 1'b0);
        tick(1);
        check_a("bwd_dead_first", 8'h00, 1'b1);
        tick(3);
        check_a("bwd_dead_last", 8'h00, 1'b1);
        tick(1);
        check_a("bwd_run", 8'hAA, 1'b0);

        // Forward -> pivot left.
        movement_sel = 4'd1;
        tick(12);
        check_a("fwd_again", 8'h55, 1'b0);
        movement_sel = 4'd3;
        tick(5);
        check_a("pivl_dead", 8'h50, 1'b1);
        tick(4);
        check_a("pivl_done", 8'h50, 1'b0);

        // Glitch rejection while stopped.
        movement_sel = 4'd0;
        tick(12);
        check_a("stopped", 8'h00, 1'b0);
        movement_sel = 4'd1;
        tick(1);
        movement_sel = 4'd0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("glitch_cmd", {28'd0, cmd_a}, 32'h0);
            check("glitch_sel", {24'd0, sel_a}, 32'h0);
        end

        // Illegal command from forward.
        movement_sel = 4'd1;
        tick(12);
        movement_sel = 4'd9;
        tick(5);
        check_a("illegal_dead", 8'h00, 1'b1);
        tick(4);
        check_a("illegal_done", 8'h00, 1'b0);
        check("illegal_cmd", {28'd0, cmd_a}, 32'h9);

        // Enable drop and re-raise with forward committed.
        movement_sel = 4'd1;
        tick(12);
        check_a("en_fwd", 8'h55, 1'b0);
        enable = 1'b0;
        tick(1);
        check_a("en_dead", 8'h00, 1'b1);
        tick(4);
        check_a("en_idle", 8'h00, 1'b0);
        enable = 1'b1;
        tick(1);
        check_a("en_back", 8'h55, 1'b0);
        check("en_back_inv", {24'd0, sel_b}, 32'hA5);

        // Reset during DEAD clears outputs without a clock edge.
        enable = 1'b0;
        tick(2);
        check_a("rst_pre", 8'h00, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("arst_sel_a",  {24'd0, sel_a}, 32'h0);
        check("arst_busy_a", {31'd0, busy_a}, 32'h0);
        check("arst_sel_b",  {24'd0, sel_b}, 32'h0);
        check("arst_busy_b", {31'd0, busy_b}, 32'h0);
        check("arst_cmd",    {28'd0, cmd_a}, 32'h0);
        tick(2);
        #2 rst = 1'b1; enable = 1'b1;
        tick(4);
        check("post_rst_cmd", {28'd0, cmd_a}, 32'h1);
        check_a("post_rst_e4", 8'h00, 1'b0);
        tick(1);
        check_a("post_rst_e5", 8'h55, 1'b0);

        // Randomized phase.
        for (int seg = 0; seg < 200; seg++) begin
            if ($urandom_range(0, 3) != 0) movement_sel = 4'($urandom_range(0, 6));
            else movement_sel = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) enable = ~enable;
            if ($urandom_range(0, 39) == 0) begin
                #2 rst = 1'b0;
                tick($urandom_range(1, 2));
                #2 rst = 1'b1;
            end
            tick($urandom_range(1, 12));
        end

        chk_en = 1'b0;
        tick(1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
